// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the WISC memory-access stage: FSM state
// encoding, default timeout and the wait-counter width.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } state_t;

  localparam int TIMEOUT_CYCLES_DEF = 32;
  localparam int WAIT_CNT_W         = 8;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for the memory stage. Cleared when an access is
// launched and incremented on every WAIT cycle. tc is raised in the
// cycle whose increment lands on LAST. The FSM's last permitted WAIT
// cycle is therefore the one where the count reaches TIMEOUT_CYCLES-1.
module mem_wait_counter
  import wisc_mem_pkg::*;
#(
  parameter int LAST = TIMEOUT_CYCLES_DEF - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WAIT_CNT_W-1:0] LAST_V = WAIT_CNT_W'(LAST);

  logic [WAIT_CNT_W-1:0] count;
  logic [WAIT_CNT_W-1:0] count_nxt;

  assign count_nxt = count + WAIT_CNT_W'(1);
  assign tc        = (count_nxt == LAST_V);

  // count register: synchronous reset/clear take priority over increment
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage WISC pipeline. Issues requests to a
// multi-cycle data memory, stalls the upstream pipe while an access is
// outstanding and latches a sticky error on misaligned, illegal or
// timed-out accesses. Optional performance counters are enabled by
// defining MEM_PERF_CNT_EN.
//
//   state | meaning
//   IDLE  | ready; issues a request when EX/MEM holds a memory op
//   WAIT  | request issued, waiting for dmem_done (bounded by timeout)
//   ERR   | sticky error; pipeline frozen until rst
module mem_access_stage
  import wisc_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       write_data_in,
  input  logic              reg_write_en_in,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [15:0]       dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_stall,
  input  logic              dmem_done,
  output logic [15:0]       read_data_out,
  output logic              reg_write_en_out,
  output logic              mem_stall_out,
  output logic              mem_err_out
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles_out,
  output logic [CNT_W-1:0]  access_cnt_out
`endif
);

  state_t state_q;
  state_t state_d;
  logic   access;
  logic   misaligned;
  logic   illegal;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  assign dmem_addr  = addr_in;
  assign dmem_wdata = write_data_in;

  assign access     = mem_read_en_in | mem_write_en_in;
  assign misaligned = access & addr_in[0];
  assign illegal    = mem_read_en_in & mem_write_en_in;

  mem_wait_counter #(
    .LAST(TIMEOUT_CYCLES - 1)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // next-state and all stage outputs; everything forced low during rst
  always_comb begin
    state_d          = state_q;
    dmem_rd          = 1'b0;
    dmem_wr          = 1'b0;
    mem_stall_out    = 1'b0;
    reg_write_en_out = 1'b0;
    read_data_out    = '0;
    mem_err_out      = 1'b0;
    cnt_clr          = 1'b0;
    cnt_en           = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!access) begin
            reg_write_en_out = reg_write_en_in;
          end else if (misaligned || illegal) begin
            mem_stall_out = 1'b1;
            state_d       = ERR;
          end else if (dmem_stall) begin
            mem_stall_out = 1'b1;
          end else begin
            dmem_rd = mem_read_en_in;
            dmem_wr = mem_write_en_in;
            if (dmem_done) begin
              reg_write_en_out = reg_write_en_in;
              read_data_out    = mem_read_en_in ? dmem_rdata : '0;
            end else begin
              mem_stall_out = 1'b1;
              cnt_clr       = 1'b1;
              state_d       = WAIT;
            end
          end
        end
        WAIT: begin
          cnt_en = 1'b1;
          if (dmem_done) begin
            reg_write_en_out = reg_write_en_in;
            read_data_out    = mem_read_en_in ? dmem_rdata : '0;
            state_d          = IDLE;
          end else begin
            mem_stall_out = 1'b1;
            if (cnt_tc) begin
              state_d = ERR;
            end
          end
        end
        ERR: begin
          mem_stall_out = 1'b1;
          mem_err_out   = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_PERF_CNT_EN
  logic acc_done;

  // an access completes on a same-cycle hit or on dmem_done while waiting
  assign acc_done = !rst && dmem_done && ((state_q == WAIT) || dmem_rd || dmem_wr);

  // saturating stall-cycle and completed-access counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_out <= '0;
      access_cnt_out   <= '0;
    end else begin
      if (mem_stall_out && (stall_cycles_out != '1)) begin
        stall_cycles_out <= stall_cycles_out + CNT_W'(1);
      end
      if (acc_done && (access_cnt_out != '1)) begin
        access_cnt_out <= access_cnt_out + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage (default build, TIMEOUT_CYCLES=4).
// Directed per-cycle vector table followed by randomized traffic
// checked against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int TO = 4;

  typedef struct packed {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rwe;
    logic [15:0] rdata;
    logic        mstall;
    logic        done;
  } in_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        stall;
    logic        rwe;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [15:0] wdata;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        mem_read_en_in;
  logic        mem_write_en_in;
  logic [15:0] addr_in;
  logic [15:0] write_data_in;
  logic        reg_write_en_in;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_stall;
  logic        dmem_done;
  logic [15:0] read_data_out;
  logic        reg_write_en_out;
  logic        mem_stall_out;
  logic        mem_err_out;

  int vectors     = 0;
  int miscompares = 0;

  vec_t tbl[$];

  // reference model: an outstanding access plus how many WAIT cycles it has used
  bit m_pending, m_err;
  int m_waited;
  bit n_pending, n_err;
  int n_waited;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read_en_in   (mem_read_en_in),
    .mem_write_en_in  (mem_write_en_in),
    .addr_in          (addr_in),
    .write_data_in    (write_data_in),
    .reg_write_en_in  (reg_write_en_in),
    .dmem_rd          (dmem_rd),
    .dmem_wr          (dmem_wr),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_stall       (dmem_stall),
    .dmem_done        (dmem_done),
    .read_data_out    (read_data_out),
    .reg_write_en_out (reg_write_en_out),
    .mem_stall_out    (mem_stall_out),
    .mem_err_out      (mem_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic rwe, input logic [15:0] rdat,
                     input logic ms, input logic dn,
                     input logic e_rd, input logic e_wr, input logic e_st, input logic e_rwe,
                     input logic e_err, input logic [15:0] e_rdat);
    vec_t v;
    v.i = '{rst: r, rd: rd, wr: wr, addr: a, wdata: wd, rwe: rwe, rdata: rdat,
            mstall: ms, done: dn};
    v.e = '{rd: e_rd, wr: e_wr, stall: e_st, rwe: e_rwe, err: e_err, rdata: e_rdat,
            addr: a, wdata: wd};
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t i, input out_t e, input string name);
    out_t got;
    @(negedge clk);
    rst             = i.rst;
    mem_read_en_in  = i.rd;
    mem_write_en_in = i.wr;
    addr_in         = i.addr;
    write_data_in   = i.wdata;
    reg_write_en_in = i.rwe;
    dmem_rdata      = i.rdata;
    dmem_stall      = i.mstall;
    dmem_done       = i.done;
    #2;
    got = '{rd: dmem_rd, wr: dmem_wr, stall: mem_stall_out, rwe: reg_write_en_out,
            err: mem_err_out, rdata: read_data_out, addr: dmem_addr, wdata: dmem_wdata};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got rd=%b wr=%b stall=%b rwe=%b err=%b rdata=%h addr=%h wdata=%h ; exp rd=%b wr=%b stall=%b rwe=%b err=%b rdata=%h addr=%h wdata=%h",
               name, got.rd, got.wr, got.stall, got.rwe, got.err, got.rdata, got.addr, got.wdata,
               e.rd, e.wr, e.stall, e.rwe, e.err, e.rdata, e.addr, e.wdata);
    end
  endtask

  // expected outputs for this cycle and the model's state after the clock edge
  task automatic model_eval(input in_t i, output out_t e);
    bit acc;
    e = '0;
    e.addr  = i.addr;
    e.wdata = i.wdata;
    n_pending = m_pending;
    n_waited  = m_waited;
    n_err     = m_err;
    acc = i.rd | i.wr;
    if (i.rst) begin
      n_pending = 0;
      n_waited  = 0;
      n_err     = 0;
    end else if (m_err) begin
      e.stall = 1;
      e.err   = 1;
    end else if (m_pending) begin
      if (i.done) begin
        e.rwe     = i.rwe;
        e.rdata   = i.rd ? i.rdata : 16'h0;
        n_pending = 0;
      end else begin
        e.stall  = 1;
        n_waited = m_waited + 1;
        if (n_waited >= TO - 1) begin
          n_err     = 1;
          n_pending = 0;
        end
      end
    end else if (!acc) begin
      e.rwe = i.rwe;
    end else if (i.addr[0] || (i.rd && i.wr)) begin
      e.stall = 1;
      n_err   = 1;
    end else if (i.mstall) begin
      e.stall = 1;
    end else begin
      e.rd = i.rd;
      e.wr = i.wr;
      if (i.done) begin
        e.rwe   = i.rwe;
        e.rdata = i.rd ? i.rdata : 16'h0;
      end else begin
        e.stall   = 1;
        n_pending = 1;
        n_waited  = 0;
      end
    end
  endtask

  task automatic model_commit();
    m_pending = n_pending;
    m_waited  = n_waited;
    m_err     = n_err;
  endtask

  initial begin
    in_t  ri;
    out_t re;
    bit   hold;

    rst = 1'b1; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0; addr_in = '0;
    write_data_in = '0; reg_write_en_in = 1'b0; dmem_rdata = '0; dmem_stall = 1'b0;
    dmem_done = 1'b0;
    m_pending = 0; m_err = 0; m_waited = 0;

    //   rst rd wr addr      wdata     rwe rdata     ms dn | rd wr st rwe err rdata
    add(1, 1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 1,   0, 0, 0, 0, 0, 16'h0000); // reset
    add(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 0, 1, 0, 16'h0000); // idle pass-through
    add(0, 1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 1,   1, 0, 0, 1, 0, 16'hBEEF); // load hit
    add(0, 1, 0, 16'h0020, 16'h0000, 1, 16'h0000, 0, 0,   1, 0, 1, 0, 0, 16'h0000); // load miss issue
    add(0, 1, 0, 16'h0020, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0020, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0020, 16'h0000, 1, 16'h1234, 0, 1,   0, 0, 0, 1, 0, 16'h1234); // done on terminal cycle
    add(0, 0, 1, 16'h0040, 16'hA5A5, 0, 16'hFFFF, 1, 0,   0, 0, 1, 0, 0, 16'h0000); // busy retry
    add(0, 0, 1, 16'h0040, 16'hA5A5, 0, 16'hFFFF, 1, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(0, 0, 1, 16'h0040, 16'hA5A5, 0, 16'hFFFF, 0, 1,   0, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 1, 16'h0042, 16'h1111, 1, 16'h5555, 0, 1,   0, 1, 0, 1, 0, 16'h0000); // store hit
    add(0, 0, 1, 16'h0050, 16'h2222, 1, 16'h0000, 0, 0,   0, 1, 1, 0, 0, 16'h0000); // store miss
    add(0, 0, 1, 16'h0050, 16'h2222, 1, 16'h0000, 1, 0,   0, 0, 1, 0, 0, 16'h0000); // dmem_stall ignored in WAIT
    add(0, 0, 1, 16'h0050, 16'h2222, 1, 16'h7777, 0, 1,   0, 0, 0, 1, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h9999, 0, 1,   0, 0, 0, 1, 0, 16'h0000); // spurious done
    add(0, 1, 0, 16'h0060, 16'h0000, 1, 16'h0000, 0, 0,   1, 0, 1, 0, 0, 16'h0000); // timeout
    add(0, 1, 0, 16'h0060, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0060, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0060, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0060, 16'h0000, 1, 16'hABCD, 0, 1,   0, 0, 1, 0, 1, 16'h0000); // ERR ignores done
    add(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0,   0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 1, 16'h0011, 16'h3333, 1, 16'h0000, 0, 1,   0, 0, 1, 0, 0, 16'h0000); // misaligned
    add(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0,   0, 0, 0, 0, 0, 16'h0000);
    add(0, 1, 1, 16'h0070, 16'h4444, 1, 16'h0000, 0, 1,   0, 0, 1, 0, 0, 16'h0000); // illegal
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0,   0, 0, 1, 0, 1, 16'h0000);
    add(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0,   0, 0, 0, 0, 0, 16'h0000);
    add(0, 1, 0, 16'h0080, 16'h0000, 1, 16'h0000, 0, 0,   1, 0, 1, 0, 0, 16'h0000); // reset mid-WAIT
    add(0, 1, 0, 16'h0080, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 1, 0, 0, 16'h0000);
    add(1, 1, 0, 16'h0080, 16'h0000, 1, 16'h0000, 0, 0,   0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hDEAD, 0, 1,   0, 0, 0, 0, 0, 16'h0000); // late done ignored
    add(0, 1, 0, 16'h0090, 16'h0000, 1, 16'hCAFE, 0, 1,   1, 0, 0, 1, 0, 16'hCAFE); // hit after reset
    add(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0,   0, 0, 0, 0, 0, 16'h0000);

    foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, $sformatf("dir[%0d]", k));

    hold = 0;
    ri   = '0;
    for (int n = 0; n < 4000; n++) begin
      int op;
      ri.rst = (n == 0) || ($urandom_range(0, 49) == 0);
      if (!hold || ri.rst) begin
        op    = int'($urandom_range(0, 39));
        ri.rd = (op == 0) || (op >= 1 && op <= 14);
        ri.wr = (op == 0) || (op >= 15 && op <= 28);
        ri.addr = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 29) == 0) ri.addr[0] = 1'b1;
        ri.wdata = 16'($urandom);
        ri.rwe   = 1'($urandom_range(0, 1));
      end
      ri.rdata  = 16'($urandom);
      ri.mstall = ($urandom_range(0, 3) == 0);
      ri.done   = ($urandom_range(0, 2) == 0);
      model_eval(ri, re);
      apply(ri, re, "rand");
      model_commit();
      hold = re.stall;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage WISC pipeline. Sits between the EX/MEM pipeline flops and the memory_WriteBack_FF flops.
- Issues data-memory read/write requests to a multi-cycle (stallmem/cache-style) data memory.
- Freezes the upstream pipeline and inserts bubbles into MEM/WB while an access is outstanding.
- Flags misaligned accesses, illegal accesses and memory timeouts as a sticky error.

Parameters:
- TIMEOUT_CYCLES, 32: maximum WAIT cycles before a timeout error; legal range 2..255.
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_read_en_in  in  1  load from EX/MEM
- mem_write_en_in  in  1  store from EX/MEM
- addr_in  in  16  byte address (EX/MEM ALU result)
- write_data_in  in  16  store data
- reg_write_en_in  in  1  register write enable from EX/MEM
- dmem_rd  out  1  memory read request
- dmem_wr  out  1  memory write request
- dmem_addr  out  16  memory address
- dmem_wdata  out  16  memory write data
- dmem_rdata  in  16  memory read data, valid with dmem_done
- dmem_stall  in  1  memory busy; cannot accept a request
- dmem_done  in  1  single-cycle completion pulse
- read_data_out  out  16  to read_data_MWB_in
- reg_write_en_out  out  1  to reg_write_en_MWB_in (bubble-gated)
- mem_stall_out  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- mem_err_out  out  1  sticky error

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset: state=IDLE, wait counter=0, error flag=0. While rst is high: dmem_rd=dmem_wr=0, mem_stall_out=0, reg_write_en_out=0, read_data_out=0, mem_err_out=0.
- Address/data: dmem_addr=addr_in and dmem_wdata=write_data_in at all times. Requests are gated only by dmem_rd/dmem_wr.
- access = mem_read_en_in | mem_write_en_in. misaligned = access & addr_in[0]. illegal = mem_read_en_in & mem_write_en_in.
- States: IDLE, WAIT, ERR. Outputs are combinational from state and inputs; state and counter are registered.
- IDLE, no access: mem_stall_out=0, reg_write_en_out=reg_write_en_in, read_data_out=0.
- IDLE, misaligned or illegal: no request issued; reg_write_en_out=0; mem_stall_out=1; next state ERR.
- IDLE, access & dmem_stall: no request; mem_stall_out=1; reg_write_en_out=0; stay in IDLE and retry next cycle.
- IDLE, access & !dmem_stall: drive dmem_rd or dmem_wr for exactly this cycle.
  - If dmem_done in the same cycle (hit): mem_stall_out=0, reg_write_en_out=reg_write_en_in, read_data_out=dmem_rdata for loads, 0 for stores. Zero added latency.
  - Otherwise: mem_stall_out=1, reg_write_en_out=0, next state WAIT, counter cleared.
- WAIT: dmem_rd=dmem_wr=0; mem_stall_out=1; reg_write_en_out=0; counter increments each cycle.
  - On dmem_done: mem_stall_out=0, reg_write_en_out=reg_write_en_in, read_data_out=dmem_rdata (load) or 0 (store); next state IDLE. EX/MEM then advances, so the next IDLE cycle sees a new instruction.
  - dmem_done in the same cycle the counter reaches TIMEOUT_CYCLES-1: done wins.
  - Counter reaches TIMEOUT_CYCLES-1 without dmem_done: next state ERR.
- ERR: terminal until rst. mem_err_out=1, mem_stall_out=1, no requests, reg_write_en_out=0.
- Spurious inputs: dmem_done in IDLE without a request is ignored. dmem_stall is ignored in WAIT.
- Reset mid-WAIT: abandons the access with no further requests. The memory's late dmem_done is then ignored per the IDLE rule.

Optional Feature:
- Macro: MEM_PERF_CNT_EN.
- Defined: adds outputs stall_cycles_out [CNT_W] and access_cnt_out [CNT_W].
  - stall_cycles_out counts cycles with mem_stall_out=1.
  - access_cnt_out counts completed accesses.
  - Both saturate at all-ones and clear on rst.
- Undefined: these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Package wisc_mem_pkg holds:
  - state encoding: IDLE=2'b00, WAIT=2'b01, ERR=2'b10
  - TIMEOUT_CYCLES default
  - counter width for the wait counter: 8 bits
- Sub-module mem_wait_counter: 8-bit counter with synchronous clear/enable and a terminal-count compare against TIMEOUT_CYCLES-1.

Test Plan:
- Load hit: rd=1, addr=0x0010, dmem_done same cycle, rdata=0xBEEF, reg_write_en_in=1 -> read_data_out=0xBEEF, reg_write_en_out=1, mem_stall_out=0, single dmem_rd pulse.
- Load miss: dmem_done 3 cycles after the request, rdata=0x1234 -> mem_stall_out=1 for 3 cycles with reg_write_en_out=0, then one cycle of read_data_out=0x1234, reg_write_en_out=1, stall=0.
- Busy retry: dmem_stall=1 for 2 cycles with wr=1 -> no dmem_wr for 2 cycles, stall=1; dmem_wr issued in cycle 3.
- Misaligned: wr=1, addr=0x0011 -> no request; mem_err_out=1 from the next cycle; stall stays 1 until rst.
- Timeout: no dmem_done after request, TIMEOUT_CYCLES=4 -> ERR entered after 3 WAIT cycles. Also check done on the terminal cycle completes normally.
- Reset mid-WAIT, then a late dmem_done -> state IDLE, no error, done ignored; next hit access completes normally.
